// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
// Multi-channel circular capture buffer for pipeline probe signals. It records
// every qualified cycle, freezes a programmable number of samples after a
// trigger, then streams one selected channel out oldest-first over valid/ready.

module pipeline_trace_buffer #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] probe_in,
  input  logic                   probe_valid,
  input  logic                   arm,
  input  logic                   trig,
  input  logic                   mode,
  input  logic [AW-1:0]          post_cnt,
  input  logic [CH_W-1:0]        rd_ch,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_last,
  input  logic                   rd_ready,
  output logic [1:0]             state,
  output logic [AW:0]            count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              cur_state;
  logic [DATA_W-1:0]   mem [N_CH][DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       remaining;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         rd_left;
  logic [CH_W-1:0]     rd_ch_q;
  logic                rd_loaded;

  logic                wr_en;
  logic [AW-1:0]       post_len;
  logic [AW-1:0]       start_ptr;
  logic [AW-1:0]       next_ptr;
  logic [DATA_W-1:0]   first_data;
  logic [DATA_W-1:0]   next_data;

  assign state = cur_state;

  // Write enable, post-trigger length and the two readout candidates (first sample and the one after the presented sample).
  always_comb begin
    wr_en      = probe_valid && !arm && (cur_state == ST_CAPTURE || cur_state == ST_POST);
    post_len   = mode ? post_cnt : AW'(DEPTH - 1);
    start_ptr  = (count == (AW+1)'(DEPTH)) ? wr_ptr : '0;
    next_ptr   = rd_ptr + 1'b1;
    first_data = '0;
    next_data  = '0;
    if (32'(rd_ch) < N_CH)
      first_data = mem[rd_ch][start_ptr];
    if (32'(rd_ch_q) < N_CH)
      next_data = mem[rd_ch_q][next_ptr];
  end

  // Sample storage has no reset; every channel is written at wr_ptr on a qualified capture cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N_CH; k++)
        mem[k][wr_ptr] <= probe_in[k*DATA_W +: DATA_W];
    end
  end

  // Capture/readout state machine with registered readout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      rd_ptr    <= '0;
      rd_left   <= '0;
      rd_ch_q   <= '0;
      rd_loaded <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (arm) begin
            cur_state <= ST_CAPTURE;
            wr_ptr    <= '0;
            count     <= '0;
          end
        end
        ST_CAPTURE, ST_POST: begin
          if (arm) begin
            cur_state <= ST_CAPTURE;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
          end else if (probe_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != (AW+1)'(DEPTH))
              count <= count + 1'b1;
            if (cur_state == ST_CAPTURE) begin
              if (trig) begin
                remaining <= post_len;
                cur_state <= (post_len == '0) ? ST_DONE : ST_POST;
              end
            end else begin
              remaining <= remaining - 1'b1;
              if (remaining == AW'(1))
                cur_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!rd_loaded) begin
            rd_loaded <= 1'b1;
            rd_ch_q   <= rd_ch;
            rd_ptr    <= start_ptr;
            rd_left   <= count;
            rd_data   <= first_data;
            rd_valid  <= 1'b1;
            rd_last   <= (count == (AW+1)'(1));
          end else if (rd_valid && rd_ready) begin
            if (rd_left == (AW+1)'(1)) begin
              cur_state <= ST_IDLE;
              rd_loaded <= 1'b0;
              rd_left   <= '0;
              rd_valid  <= 1'b0;
              rd_data   <= '0;
              rd_last   <= 1'b0;
            end else begin
              rd_ptr  <= next_ptr;
              rd_data <= next_data;
              rd_left <= rd_left - 1'b1;
              rd_last <= (rd_left == (AW+1)'(2));
            end
          end
        end
        default: cur_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
- Parametrised multi-channel capture buffer for pipeline-stage observation signals (decode/exe/mem/wb register IDs, operands, results, write enables).
- Replaces bench-only probing with a synthesizable trace: samples N_CH probe channels on every qualified cycle into a circular buffer.
- Freezes on a trigger plus a programmable post-trigger count, then streams one selected channel out over a valid/ready port.
- Sits beside the ImageFilter core; probe_in is driven by the core's debug outputs.

Parameters:
N_CH, 4, number of probe channels
DATA_W, 32, width of each channel
DEPTH, 16, entries per channel (power of two, >=2)
AW, $clog2(DEPTH), pointer width (derived; not overridden)
CH_W, $clog2(N_CH) (min 1), channel-select width (derived)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
probe_in  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
probe_valid  in  1  sample qualifier; one write per cycle when high
arm  in  1  start/restart capture
trig  in  1  trigger condition, only honoured with probe_valid
mode  in  1  0 = fill mode (post count = DEPTH-1), 1 = programmable post count
post_cnt  in  AW  samples stored after the trigger sample (mode 1)
rd_ch  in  CH_W  channel to stream out; latched on entry to DONE
rd_valid  out  1  readout data valid
rd_data  out  DATA_W  readout sample, oldest first
rd_last  out  1  high with final readout sample
rd_ready  in  1  consumer accepts rd_data when rd_valid & rd_ready
state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
count  out  AW+1  valid entries held (0..DEPTH)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wr_ptr=0, count=0, rd_valid=0, rd_data=0, rd_last=0, remaining=0. Buffer contents are don't-care. Reset mid-capture or mid-readout aborts immediately.
- IDLE: arm=1 -> CAPTURE next cycle. wr_ptr and count clear to 0. trig on the same cycle as arm is ignored.
- CAPTURE: each probe_valid cycle writes all N_CH channels at wr_ptr. wr_ptr increments modulo DEPTH. count saturates at DEPTH (oldest entry overwritten).
- CAPTURE trigger: probe_valid & trig writes the trigger sample as normal, then loads remaining = (mode ? post_cnt : DEPTH-1).
  - remaining==0 -> DONE.
  - otherwise -> POST.
- POST: each probe_valid writes and decrements remaining. The write that brings remaining to 0 moves the block to DONE on the next cycle. trig is ignored in POST.
- arm=1 in CAPTURE or POST restarts: clear pointers/count, stay in or return to CAPTURE. arm is ignored in DONE.
- DONE entry:
  - rd_ch latched.
  - rd_ptr = (count==DEPTH) ? wr_ptr : 0.
  - rd_left = count.
  - rd_valid rises on the first DONE cycle.
  - rd_data = mem[rd_ch][rd_ptr], from a registered output.
- DONE handshake: on rd_valid & rd_ready, rd_ptr advances modulo DEPTH and the next sample is presented the following cycle. rd_data and rd_valid stay stable while rd_ready=0.
- rd_last=1 exactly when the sample presented is the final one (rd_left==1).
- Final handshake: rd_valid=0 and rd_data=0 next cycle; state -> IDLE.
- Writes are disabled in DONE and IDLE; probe_valid is ignored.
- Latency:
  - trigger sample to DONE: post_cnt+1 qualified samples.
  - DONE entry to first rd_valid: 1 cycle.
  - throughput: 1 sample/cycle with rd_ready held high.
- rd_ch >= N_CH: rd_data reads 0.

Test Plan:
- Reset: drive rst_n=0 mid-POST with N_CH=4, DATA_W=32, DEPTH=8 -> same cycle state=0, count=0, rd_valid=0. After release, probe_valid is ignored until arm.
- Fill mode:
  - Stimulus: mode=0; arm; ch0 = sample index 0,1,2,...; trig at index 3.
  - Response: DONE after index 10, count=8.
  - rd_ch=0 streams 3..10; rd_last with 10; state returns to 0.
- Programmable post:
  - Stimulus: mode=1, post_cnt=2; 20 samples before trig at index 20.
  - Response: DONE after index 22; readout 15..22, oldest first across pointer wrap.
- Post count zero, partial fill:
  - Stimulus: mode=1, post_cnt=0; trig on the 3rd qualified sample after arm.
  - Response: count=3; readout of 3 samples, rd_last on the 3rd.
- Backpressure/channel:
  - Stimulus: rd_ch=2, channel 2 = 0xA000_0000+index; rd_ready toggled 1,0,0,1.
  - Response: rd_data is held while stalled; no sample is dropped or duplicated.
- Restart/ignore:
  - arm+trig in the same IDLE cycle -> trig ignored.
  - arm during POST -> count=0, back in CAPTURE.
  - arm during DONE -> ignored; readout completes.
